// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access, RISC-V byte/half/word lane
// handling, alignment and funct3 checks, and a bounded wait for the bus ack.
module lsu #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic [31:0] load_data,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   // Last counter value before the abort; the ack is still honoured in that cycle.
   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [2:0]  funct3_reg, funct3_next;
   logic [1:0]  lane_reg, lane_next;
   logic        mem_req_reg, mem_req_next;
   logic        mem_we_reg, mem_we_next;
   logic [31:0] mem_addr_reg, mem_addr_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
   logic        done_reg, done_next;
   logic [31:0] load_data_reg, load_data_next;
   logic        fault_reg, fault_next;

   function automatic logic is_legal(input logic st, input logic [2:0] f3);
      if (st)
         return f3 inside {3'b000, 3'b001, 3'b010};
      return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         funct3_reg    <= '0;
         lane_reg      <= '0;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_wstrb_reg <= '0;
         done_reg      <= 1'b0;
         load_data_reg <= '0;
         fault_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         funct3_reg    <= funct3_next;
         lane_reg      <= lane_next;
         mem_req_reg   <= mem_req_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         mem_wstrb_reg <= mem_wstrb_next;
         done_reg      <= done_next;
         load_data_reg <= load_data_next;
         fault_reg     <= fault_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      funct3_next    = funct3_reg;
      lane_next      = lane_reg;
      mem_req_next   = mem_req_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      mem_wstrb_next = mem_wstrb_reg;
      done_next      = 1'b0;
      load_data_next = load_data_reg;
      fault_next     = fault_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               funct3_next = funct3;
               lane_next   = addr[1:0];
               if (!is_legal(is_store, funct3) || is_misaligned(funct3, addr[1:0])) begin
                  // Rejected before any bus traffic.
                  state_next     = RESP;
                  done_next      = 1'b1;
                  fault_next     = 1'b1;
                  load_data_next = '0;
               end else begin
                  state_next    = BUS;
                  cnt_next      = '0;
                  mem_req_next  = 1'b1;
                  mem_we_next   = is_store;
                  mem_addr_next = {addr[31:2], 2'b00};
                  case (funct3[1:0])
                     2'b00: begin
                        mem_wstrb_next = 4'b0001 << addr[1:0];
                        mem_wdata_next = {4{store_data[7:0]}};
                     end
                     2'b01: begin
                        mem_wstrb_next = 4'b0011 << addr[1:0];
                        mem_wdata_next = {2{store_data[15:0]}};
                     end
                     default: begin
                        mem_wstrb_next = 4'b1111;
                        mem_wdata_next = store_data;
                     end
                  endcase
                  if (!is_store)
                     mem_wstrb_next = 4'b0000;
               end
            end
         end
         BUS: begin
            if (mem_ack) begin
               state_next     = RESP;
               mem_req_next   = 1'b0;
               done_next      = 1'b1;
               fault_next     = 1'b0;
               load_data_next = mem_we_reg ? 32'd0 : extract(funct3_reg, lane_reg, mem_rdata);
            end else begin
               cnt_next = cnt_reg + 8'd1;
               if (cnt_reg == CNT_LAST) begin
                  state_next     = RESP;
                  mem_req_next   = 1'b0;
                  done_next      = 1'b1;
                  fault_next     = 1'b1;
                  load_data_next = '0;
               end
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign req_ready = (state_reg == IDLE);
   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_wstrb = mem_wstrb_reg;
   assign done      = done_reg;
   assign load_data = load_data_reg;
   assign fault     = fault_reg;

endmodule
